// File: rtl/ss_addresses_pkg.sv
// ss_addresses: savestate bus widths, sequencer sizing constants and state type.
package ss_addresses;

  localparam int SS_BUS_WIDTH      = 10;
  localparam int SS_DATA_WIDTH     = 32;

  // Slices serialise a bus word through 4-bit memories; the settle hold must cover that walk.
  localparam int SS_MEM_WORD_WIDTH = 4;
  localparam int SS_MIN_SETTLE     = SS_DATA_WIDTH / SS_MEM_WORD_WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE,
    S_SETTLE,
    S_OUT,
    L_WAIT,
    L_WRITE,
    DEFAULTS,
    FINISH
  } ss_seq_state_t;

endpackage

// File: rtl/ss_bus_sequencer_settle_timer.sv
// ss_settle_timer: loadable down-counter giving one expire pulse after SETTLE_CYCLES cycles.
module ss_settle_timer #(
  parameter int SETTLE_CYCLES = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic expire
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  logic [CNT_W-1:0] settle_cnt;
  logic             armed;

  // Load starts a hold that expires on its SETTLE_CYCLES-th cycle; armed keeps the pulse single.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else if (load) begin
      settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
      armed      <= 1'b1;
    end else if (armed) begin
      if (settle_cnt == '0) begin
        armed <= 1'b0;
      end else begin
        settle_cnt <= settle_cnt - 1'b1;
      end
    end
  end

  assign expire = armed && (settle_cnt == '0);

endmodule

// File: rtl/ss_bus_sequencer.sv
// ss_bus_sequencer: savestate bus master walking addresses 0..ADDR_COUNT-1 for save/load.
// Optional build macro SS_SEQ_DEFAULTS_EN adds start_defaults and a restore-defaults pass.
module ss_bus_sequencer
  import ss_addresses::*;
#(
  parameter int                      ADDR_COUNT    = 256,
  parameter int                      SETTLE_CYCLES = 10,
  parameter logic [SS_BUS_WIDTH-1:0] IDLE_ADDR     = {SS_BUS_WIDTH{1'b1}}
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_save,
  input  logic                     start_load,
`ifdef SS_SEQ_DEFAULTS_EN
  input  logic                     start_defaults,
`endif
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [SS_DATA_WIDTH-1:0] save_data,
  output logic                     save_valid,
  input  logic                     save_ready,
  input  logic [SS_DATA_WIDTH-1:0] load_data,
  input  logic                     load_valid,
  output logic                     load_ready,
  output logic [SS_BUS_WIDTH-1:0]  ss_bus_addr,
  output logic [SS_DATA_WIDTH-1:0] ss_bus_in,
  output logic                     ss_bus_wren,
  output logic                     ss_bus_reset_n,
  input  logic [SS_DATA_WIDTH-1:0] ss_bus_out
);

  localparam int CW = SS_BUS_WIDTH + 1;

  if (SETTLE_CYCLES < SS_MIN_SETTLE) begin : g_bad_settle
    $error("ss_bus_sequencer: SETTLE_CYCLES is below SS_MIN_SETTLE");
  end
  if (ADDR_COUNT < 1 || ADDR_COUNT > (1 << SS_BUS_WIDTH) - 1) begin : g_bad_count
    $error("ss_bus_sequencer: ADDR_COUNT out of range");
  end

  ss_seq_state_t   state, next_state;
  logic [CW-1:0]   addr_cnt;
  logic [CW-1:0]   addr_next;
  logic            last_addr;
  logic            cnt_clear, cnt_inc, cap_save, cap_load, timer_load;
  logic            timer_expire;
  logic            start_def;

`ifdef SS_SEQ_DEFAULTS_EN
  assign start_def = start_defaults;
`else
  assign start_def = 1'b0;
`endif

  assign addr_next = addr_cnt + 1'b1;
  assign last_addr = (addr_next == CW'(ADDR_COUNT));

  ss_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (timer_load),
    .expire (timer_expire)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state, datapath controls and bus/handshake outputs, all decoded from the current state.
  always_comb begin
    next_state     = state;
    cnt_clear      = 1'b0;
    cnt_inc        = 1'b0;
    cap_save       = 1'b0;
    cap_load       = 1'b0;
    timer_load     = 1'b0;
    busy           = (state != IDLE);
    done           = (state == FINISH);
    save_valid     = (state == S_OUT);
    load_ready     = (state == L_WAIT);
    ss_bus_wren    = (state == L_WRITE);
    ss_bus_addr    = IDLE_ADDR;
    ss_bus_reset_n = 1'b1;

    if (state == S_SETTLE || state == S_OUT || state == L_WRITE || state == DEFAULTS) begin
      ss_bus_addr = addr_cnt[SS_BUS_WIDTH-1:0];
    end
`ifdef SS_SEQ_DEFAULTS_EN
    if (state == DEFAULTS) ss_bus_reset_n = 1'b0;
`endif

    if (state != IDLE && abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!abort) begin
            if (start_save) begin
              cnt_clear  = 1'b1;
              timer_load = 1'b1;
              next_state = S_SETTLE;
            end else if (start_load) begin
              cnt_clear  = 1'b1;
              next_state = L_WAIT;
            end else if (start_def) begin
              cnt_clear  = 1'b1;
              timer_load = 1'b1;
              next_state = DEFAULTS;
            end
          end
        end
        S_SETTLE: begin
          if (timer_expire) begin
            cap_save   = 1'b1;
            next_state = S_OUT;
          end
        end
        S_OUT: begin
          if (save_ready) begin
            cnt_inc = 1'b1;
            if (last_addr) begin
              next_state = FINISH;
            end else begin
              timer_load = 1'b1;
              next_state = S_SETTLE;
            end
          end
        end
        L_WAIT: begin
          if (load_valid) begin
            cap_load   = 1'b1;
            timer_load = 1'b1;
            next_state = L_WRITE;
          end
        end
        L_WRITE: begin
          if (timer_expire) begin
            cnt_inc    = 1'b1;
            next_state = last_addr ? FINISH : L_WAIT;
          end
        end
        DEFAULTS: begin
          if (timer_expire) begin
            cnt_inc = 1'b1;
            if (last_addr) next_state = FINISH;
            else           timer_load = 1'b1;
          end
        end
        FINISH:  next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Address counter plus the captured read word and the latched write word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_cnt  <= '0;
      save_data <= '0;
      ss_bus_in <= '0;
    end else begin
      if (cnt_clear)    addr_cnt <= '0;
      else if (cnt_inc) addr_cnt <= addr_next;
      if (cap_save) save_data <= ss_bus_out;
      if (cap_load) ss_bus_in <= load_data;
    end
  end

endmodule

// File: doc/ss_bus_sequencer.md
Name: ss_bus_sequencer

Overview:
Master for the savestate bus. Walks every savestate bus address in order. On save, it reads each word from the bus_memory and register slices and streams it out over a valid/ready port. On load, it accepts words over a valid/ready port and writes each one to the bus. Sits between the host savestate bridge and the bus fan-out; the external read-data mux feeds ss_bus_out back to it.

Parameters:
ADDR_COUNT, 256, number of bus addresses to transfer, starting at address 0 (range 1..2^SS_BUS_WIDTH-1)
SETTLE_CYCLES, 10, cycles each address is held before read data is sampled or the write is released; must be >= SS_DATA_WIDTH/4 + 2 (SS_DATA_WIDTH/4 = number of 4-bit memory words per bus word)
IDLE_ADDR, all ones (SS_BUS_WIDTH bits), address driven when no transfer is active; must lie outside every slice range

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start_save  in  1  one-cycle pulse; begins a save pass
start_load  in  1  one-cycle pulse; begins a load pass
abort  in  1  cancels the current pass
busy  out  1  high while a pass is active
done  out  1  one-cycle pulse when a pass completes
save_data  out  SS_DATA_WIDTH  word read from the bus
save_valid  out  1  save_data is valid
save_ready  in  1  downstream accepts save_data
load_data  in  SS_DATA_WIDTH  word to be written to the bus
load_valid  in  1  load_data is valid
load_ready  out  1  sequencer accepts load_data
ss_bus_addr  out  SS_BUS_WIDTH  bus address
ss_bus_in  out  SS_DATA_WIDTH  write data to the slices
ss_bus_wren  out  1  write enable to the slices
ss_bus_reset_n  out  1  restore-defaults strobe to the slices, active low
ss_bus_out  in  SS_DATA_WIDTH  muxed read data from the slices

Behaviour:
- Reset values:
  - ss_bus_addr = IDLE_ADDR; ss_bus_in = 0; ss_bus_wren = 0; ss_bus_reset_n = 1.
  - busy = 0; done = 0; save_valid = 0; load_ready = 0; save_data = 0.
  - State = IDLE.
- Internal counters:
  - addr_cnt: SS_BUS_WIDTH+1 bits, so addr_cnt == ADDR_COUNT is representable without wrap.
  - settle_cnt: $clog2(SETTLE_CYCLES+1) bits.
- IDLE:
  - start_save takes priority if both starts arrive in the same cycle.
  - On start_save: addr_cnt = 0, go to S_SETTLE. On start_load: addr_cnt = 0, go to L_WAIT.
  - Starts received while busy are ignored.
- S_SETTLE:
  - Drive ss_bus_addr = addr_cnt, ss_bus_wren = 0.
  - Count SETTLE_CYCLES cycles, then capture save_data <= ss_bus_out and go to S_OUT.
- S_OUT:
  - save_valid = 1; address stays held; save_data is stable until accepted.
  - On save_valid & save_ready: addr_cnt increments.
  - If the new addr_cnt == ADDR_COUNT go to FINISH, else go to S_SETTLE.
  - The address change restarts the slice.
- L_WAIT:
  - ss_bus_addr = IDLE_ADDR, load_ready = 1.
  - On load_valid & load_ready: latch ss_bus_in <= load_data and go to L_WRITE.
- L_WRITE:
  - Drive ss_bus_addr = addr_cnt and ss_bus_wren = 1 from the first cycle; hold for SETTLE_CYCLES cycles.
  - Then drop ss_bus_wren, increment addr_cnt.
  - Go to FINISH if the new addr_cnt == ADDR_COUNT, else go to L_WAIT.
  - The slice captures the write on its first active cycle; holding wren longer is harmless.
- FINISH:
  - done = 1 for exactly one cycle, ss_bus_addr = IDLE_ADDR, then go to IDLE.
- busy = 1 in every state except IDLE.
- abort (any non-IDLE state):
  - Go to IDLE on the next edge; ss_bus_wren = 0, save_valid = 0, load_ready = 0, ss_bus_addr = IDLE_ADDR.
  - No done pulse.
  - abort in IDLE is a no-op; abort wins over start in the same cycle.
- ADDR_COUNT = 1: a single transfer, then FINISH.
- Throughput with zero backpressure:
  - Save: SETTLE_CYCLES+1 cycles per word.
  - Load: SETTLE_CYCLES+1 cycles per word.
- Asynchronous reset mid-pass returns all outputs to their reset values immediately. A partially loaded state is not rolled back.

Optional Feature:
SS_SEQ_DEFAULTS_EN.
- Defined: adds input start_defaults.
  - A pulse in IDLE starts a DEFAULTS pass over 0..ADDR_COUNT-1.
  - Each address is driven for SETTLE_CYCLES with ss_bus_reset_n = 0 and ss_bus_wren = 0; ends with a done pulse.
  - Priority: save > load > defaults.
- Undefined: no start_defaults port; ss_bus_reset_n is tied to 1.

Decomposition:
- Package ss_addresses already provides SS_BUS_WIDTH and SS_DATA_WIDTH.
- Add to ss_addresses:
  - SS_MEM_WORD_WIDTH = 4.
  - SS_MIN_SETTLE = SS_DATA_WIDTH/SS_MEM_WORD_WIDTH + 2.
  - typedef enum ss_seq_state_t {IDLE, S_SETTLE, S_OUT, L_WAIT, L_WRITE, DEFAULTS, FINISH}.
- A compile-time check fails the build if SETTLE_CYCLES < SS_MIN_SETTLE.
- Sub-module ss_settle_timer: load, count down, expire pulse; used by the settle, write and defaults holds.

Test Plan:
- Save, no backpressure: ADDR_COUNT=4, SETTLE_CYCLES=10, bus_memory model preloaded with words 0x11111111..0x44444444, save_ready=1 -> 4 save beats in address order; consecutive beats 11 cycles apart; done pulses once; busy falls the cycle after done.
- Load then readback: load 0xDEADBEEF, 0x01234567, 0x89ABCDEF, 0x0F0F0F0F with load_valid held high -> each ss_bus_wren window lasts 10 cycles at addresses 0..3; a following save returns the identical words.
- Backpressure: save_ready low for 7 cycles at address 2 -> save_valid, save_data and ss_bus_addr=2 stay stable; no address advance until the handshake completes.
- Abort: abort during L_WRITE at address 1 -> next cycle ss_bus_wren=0, ss_bus_addr=IDLE_ADDR, busy=0, no done; a new start_load restarts at address 0.
- Simultaneous start_save & start_load in IDLE -> save pass runs; a start_load pulse mid-pass is ignored; exactly ADDR_COUNT save beats.
- Asynchronous reset asserted mid S_SETTLE (not on a clock edge) -> outputs immediately return to their reset values; the sequencer returns to IDLE after release.
